// File: rtl/fir_ctrl_pkg.sv
// Shared FIR control definitions: FSM state encodings and width helpers
// used by the coefficient loader and sibling FIR control blocks.
package fir_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ARMED  = 2'd2
    } fir_state_e;

    function automatic int fir_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) r = r + 1;
        end
        return r;
    endfunction

    // Index width with a floor of one bit so a single-tap filter still has a port.
    function automatic int fir_addr_w(input int n);
        return (fir_clog2(n) < 1) ? 1 : fir_clog2(n);
    endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Double-buffered FIR coefficient loader: writes land in a shadow bank and are
// swapped atomically into the active bank on a sample strobe after commit.
module fir_coeff_loader
    import fir_ctrl_pkg::*;
#(
    parameter int                                COEFF_WIDTH    = 8,
    parameter int                                NUM_TAPS       = 4,
    parameter logic [COEFF_WIDTH*NUM_TAPS-1:0]   DEFAULT_COEFFS = '0,
    parameter int                                ADDR_W         = fir_addr_w(NUM_TAPS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              sample_stb,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [ADDR_W-1:0]                 wr_addr,
    input  logic [COEFF_WIDTH-1:0]            wr_data,
    input  logic                              commit,
    output logic [COEFF_WIDTH*NUM_TAPS-1:0]   packed_coeffs,
    output logic                              swap_done,
    output logic                              settled,
    output logic                              wr_err
);

    localparam int CNT_W = fir_clog2(NUM_TAPS + 1);

    fir_state_e                               state_q, state_d;
    logic [CNT_W-1:0]                         cnt_q, cnt_d;
    logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0]     shadow_q;
    logic [NUM_TAPS-1:0][COEFF_WIDTH-1:0]     active_q;
    logic                                     swap;
    logic                                     wr_fire;
    logic                                     addr_ok;

    assign wr_fire       = wr_valid && wr_ready;
    assign addr_ok       = ({1'b0, wr_addr} < (ADDR_W+1)'(NUM_TAPS));
    assign packed_coeffs = active_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        swap    = 1'b0;
        unique case (state_q)
            ST_SETTLE: begin
                // A commit abandons the settle window; the strobe it coincides with is not counted.
                if (commit) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end else if (sample_stb && (cnt_q < CNT_W'(NUM_TAPS))) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NUM_TAPS - 1)) state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (commit) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (sample_stb) begin
                    swap    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SETTLE;
            cnt_q     <= '0;
            wr_ready  <= 1'b0;
            settled   <= 1'b0;
            swap_done <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ready  <= (state_d != ST_ARMED);
            settled   <= (state_d == ST_IDLE);
            swap_done <= swap;
            wr_err    <= wr_fire && !addr_ok;
        end
    end

    // Shadow accepts writes only while ready, so it is frozen for the whole ARMED window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= DEFAULT_COEFFS;
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (wr_fire && addr_ok && (wr_addr == ADDR_W'(i))) shadow_q[i] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) active_q <= DEFAULT_COEFFS;
        else if (swap) active_q <= shadow_q;
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scenario bench for fir_coeff_loader: expected active banks are queued at
// commit time from a shadow model and popped when swap_done is observed.
module tb_fir_coeff_loader;

    localparam int          CW   = 8;
    localparam int          NT   = 4;
    localparam int          AW   = 3;
    localparam logic [31:0] DEFV = 32'h01010101;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sample_stb, wr_valid, wr_ready, commit;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;
    logic [31:0]   packed_coeffs;
    logic          swap_done, settled, wr_err;

    int errors = 0;
    int checks = 0;

    logic [NT-1:0][CW-1:0] sh_m;
    logic [31:0]           exp_q[$];

    fir_coeff_loader #(
        .COEFF_WIDTH(CW), .NUM_TAPS(NT), .DEFAULT_COEFFS(DEFV), .ADDR_W(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit),
        .packed_coeffs(packed_coeffs), .swap_done(swap_done), .settled(settled),
        .wr_err(wr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Strobe while ARMED: the swap must appear on this edge with the queued bank.
    task automatic swap_strobe(input string name);
        logic [31:0] exp;
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        checks++;
        if (swap_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_swap_done: got %b expected 1", name, swap_done);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_queue: swap seen with nothing expected", name);
        end else begin
            exp = exp_q.pop_front();
            chk({name, "_bank"}, packed_coeffs, exp);
        end
        tick();
        chk({name, "_swap_done_fall"}, 32'(swap_done), 32'd0);
    endtask

    task automatic settle(input string name);
        for (int i = 0; i < NT; i++) begin
            sample_stb = 1'b1;
            tick();
            sample_stb = 1'b0;
            chk($sformatf("%s_settled_%0d", name, i), 32'(settled), (i == NT-1) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [CW-1:0] d, input logic with_commit);
        logic rdy;
        rdy      = wr_ready;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        commit   = with_commit;
        tick();
        wr_valid = 1'b0;
        commit   = 1'b0;
        if (rdy && (int'(a) < NT)) sh_m[a] = d;
        if (with_commit) exp_q.push_back(sh_m);
        chk("wr_err_pulse", 32'(wr_err), (rdy && (int'(a) >= NT)) ? 32'd1 : 32'd0);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        exp_q.push_back(sh_m);
        chk("armed_wr_ready", 32'(wr_ready), 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_stb = 0; wr_valid = 0; commit = 0; wr_addr = '0; wr_data = '0;
        sh_m = DEFV;
        #12;
        chk("rst_coeffs", packed_coeffs, DEFV);
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_settled", 32'(settled), 32'd0);
        chk("rst_swap_done", 32'(swap_done), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_wr_ready", 32'(wr_ready), 32'd1);
        tick(); tick();
        chk("nostb_settled", 32'(settled), 32'd0);
        chk("nostb_coeffs", packed_coeffs, DEFV);
        settle("init");
    endtask

    task automatic test_swap();
        write(3'd0, 8'h10, 1'b0);
        write(3'd1, 8'h20, 1'b0);
        write(3'd2, 8'h30, 1'b0);
        write(3'd3, 8'h40, 1'b0);
        do_commit();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("armed_hold_coeffs", packed_coeffs, DEFV);
            chk("armed_no_swap", 32'(swap_done), 32'd0);
        end
        swap_strobe("swap1");
        chk("swap1_value", packed_coeffs, 32'h40302010);
        chk("swap1_settled", 32'(settled), 32'd0);
        settle("swap1");
    endtask

    task automatic test_write_with_commit();
        write(3'd2, 8'hFF, 1'b1);
        chk("wc_wr_ready", 32'(wr_ready), 32'd0);
        swap_strobe("wc");
        chk("wc_value", packed_coeffs, 32'h40FF2010);
        settle("wc");
    endtask

    task automatic test_bad_addr();
        write(3'd4, 8'hAA, 1'b0);
        tick();
        chk("bad_wr_err_fall", 32'(wr_err), 32'd0);
        do_commit();
        swap_strobe("bad");
        chk("bad_value", packed_coeffs, 32'h40FF2010);
        settle("bad");
    endtask

    task automatic test_back_to_back();
        write(3'd0, 8'h55, 1'b0);
        do_commit();
        swap_strobe("b2b_a");
        // Two of four settle strobes, then re-commit.
        for (int i = 0; i < 2; i++) begin
            sample_stb = 1'b1; tick(); sample_stb = 1'b0;
        end
        write(3'd3, 8'h66, 1'b0);
        do_commit();
        chk("b2b_settled", 32'(settled), 32'd0);
        // Commit and writes in ARMED are ignored.
        commit = 1'b1; tick(); commit = 1'b0;
        write(3'd1, 8'h77, 1'b0);
        chk("b2b_armed_coeffs", packed_coeffs, 32'h40FF2055);
        swap_strobe("b2b_b");
        chk("b2b_value", packed_coeffs, 32'h66FF2055);
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);
        // Strobe with commit in SETTLE: commit wins, strobe not counted.
        sample_stb = 1'b1; tick(); sample_stb = 1'b0;
        sample_stb = 1'b1; commit = 1'b1; tick(); sample_stb = 1'b0; commit = 1'b0;
        exp_q.push_back(sh_m);
        chk("race_wr_ready", 32'(wr_ready), 32'd0);
        chk("race_settled", 32'(settled), 32'd0);
        swap_strobe("race");
        settle("race");
    endtask

    task automatic test_reset_armed();
        write(3'd1, 8'h99, 1'b0);
        do_commit();
        #2 rst_n = 1'b0;
        #1;
        chk("ra_coeffs", packed_coeffs, DEFV);
        chk("ra_wr_ready", 32'(wr_ready), 32'd0);
        chk("ra_settled", 32'(settled), 32'd0);
        exp_q.delete();
        sh_m = DEFV;
        #10 rst_n = 1'b1;
        tick();
        for (int i = 0; i < NT; i++) begin
            sample_stb = 1'b1; tick(); sample_stb = 1'b0;
            chk("ra_no_swap", 32'(swap_done), 32'd0);
            chk("ra_hold_coeffs", packed_coeffs, DEFV);
        end
        chk("ra_settled_after", 32'(settled), 32'd1);
        do_commit();
        swap_strobe("ra_shadow");
    endtask

    initial begin
        test_reset();
        test_swap();
        test_write_with_commit();
        test_bad_addr();
        test_back_to_back();
        test_reset_armed();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
